uart_tx_cfg: RTL

Runtime-configurable UART transmitter with an input byte FIFO. It supports 5-8 data bits, no/even/odd parity, 1 or 2 stop bits, and a runtime baud divisor. It sits between a host byte source and the serial pin, and replaces the fixed 8N1 transmitter wherever the frame format or baud rate must be selected by software. The FIFO allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_tx_cfg.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART transmitter.
//   tx_state_e - transmitter FSM state encoding
//   PAR_*      - parity-mode codes as seen on i_Parity (2'b11 also means none)
//   data_len   - maps the 2-bit data-length code to a bit count of 5..8
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic [3:0] data_len(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO feeding the transmitter.
//   clk, i_Rst_L  - clock, asynchronous active-low reset
//   i_push        - write i_wdata (ignored when full)
//   i_pop         - drop the head entry (ignored when empty)
//   o_rdata       - head entry, valid while !o_empty
//   o_full/o_empty/o_count - occupancy status, o_count is 0..FIFO_DEPTH
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_Rst_L,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [7:0]       i_wdata,
    output logic [7:0]       o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with input FIFO.
//   clk, i_Rst_L     - clock, asynchronous active-low reset
//   i_Clks_Per_Bit   - bit period in clocks (0 and 1 behave as 2)
//   i_Data_Bits      - 5..8 data bits, i_Parity - none/even/odd, i_Two_Stop - 2 stop bits
//   i_TX_DV/i_TX_Byte - byte write strobe and data
//   o_TX_Ready, o_Fifo_Count, o_Overflow - FIFO status, dropped-write pulse
//   o_TX_Active, o_TX_Serial, o_TX_Done - frame in progress, line, end-of-frame pulse
// Configuration is sampled at the pop that starts each frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_Rst_L,
    input  logic [DIV_W-1:0] i_Clks_Per_Bit,
    input  logic [1:0]       i_Data_Bits,
    input  logic [1:0]       i_Parity,
    input  logic             i_Two_Stop,
    input  logic             i_TX_DV,
    input  logic [7:0]       i_TX_Byte,
    output logic             o_TX_Ready,
    output logic [CNT_W-1:0] o_Fifo_Count,
    output logic             o_Overflow,
    output logic             o_TX_Active,
    output logic             o_TX_Serial,
    output logic             o_TX_Done
);

    tx_state_e        r_state, w_state_d;
    logic [DIV_W-1:0] r_clk_cnt, w_clk_cnt_d;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit_idx, w_bit_idx_d;
    logic [2:0]       r_last_idx;
    logic             r_stop_cnt, w_stop_cnt_d;
    logic [7:0]       r_data;
    logic             r_par_en, r_par_bit, r_two_stop;
    logic             r_overflow;

    logic             w_full, w_empty, w_push, w_pop, w_done, w_bit_end, w_serial;
    logic [7:0]       w_rdata, w_mask;
    logic [DIV_W-1:0] w_div_clamped;

    assign w_push        = i_TX_DV && !w_full;
    assign w_div_clamped = (i_Clks_Per_Bit < DIV_W'(2)) ? DIV_W'(2) : i_Clks_Per_Bit;
    assign w_mask        = 8'hFF >> (4'd8 - data_len(i_Data_Bits));
    assign w_bit_end     = (r_clk_cnt == r_div - DIV_W'(1));

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .i_Rst_L (i_Rst_L),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (i_TX_Byte),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_Fifo_Count)
    );

    always_comb begin
        w_state_d    = r_state;
        w_clk_cnt_d  = r_clk_cnt + DIV_W'(1);
        w_bit_idx_d  = r_bit_idx;
        w_stop_cnt_d = r_stop_cnt;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            StIdle: begin
                w_clk_cnt_d = '0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_clk_cnt_d = '0;
                    w_bit_idx_d = '0;
                    w_state_d   = StData;
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_clk_cnt_d = '0;
                    if (r_bit_idx == r_last_idx) begin
                        w_stop_cnt_d = 1'b0;
                        w_state_d    = r_par_en ? StParity : StStop;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end
            end
            StParity: begin
                if (w_bit_end) begin
                    w_clk_cnt_d  = '0;
                    w_stop_cnt_d = 1'b0;
                    w_state_d    = StStop;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_clk_cnt_d = '0;
                    if (r_two_stop && !r_stop_cnt) begin
                        w_stop_cnt_d = 1'b1;
                    end else begin
                        w_done = 1'b1;
                        // Chain straight into the next frame when data is waiting.
                        if (!w_empty) begin
                            w_pop     = 1'b1;
                            w_state_d = StStart;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                w_clk_cnt_d = '0;
                w_state_d   = StIdle;
            end
        endcase
    end

    always_comb begin
        w_serial = 1'b1;
        case (r_state)
            StStart:  w_serial = 1'b0;
            StData:   w_serial = r_data[r_bit_idx];
            StParity: w_serial = r_par_bit;
            default:  w_serial = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state    <= StIdle;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_div      <= DIV_W'(2);
            r_last_idx <= 3'd7;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_clk_cnt  <= w_clk_cnt_d;
            r_bit_idx  <= w_bit_idx_d;
            r_stop_cnt <= w_stop_cnt_d;
            r_overflow <= i_TX_DV && w_full;
            if (w_pop) begin
                r_div      <= w_div_clamped;
                r_last_idx <= 3'(data_len(i_Data_Bits) - 4'd1);
                r_data     <= w_rdata;
                r_par_en   <= (i_Parity == PAR_EVEN) || (i_Parity == PAR_ODD);
                // Even parity is the plain XOR of the sent bits; odd inverts it.
                r_par_bit  <= (^(w_rdata & w_mask)) ^ (i_Parity == PAR_ODD);
                r_two_stop <= i_Two_Stop;
            end
        end
    end

    assign o_TX_Serial = w_serial;
    assign o_TX_Active = (r_state != StIdle);
    assign o_TX_Done   = w_done;
    assign o_TX_Ready  = !w_full;
    assign o_Overflow  = r_overflow;

endmodule
